// File: rtl/rst_seq_pkg.sv
// Shared state encoding and counter sizing for the reset sequencer and its bench-visible debug state.
package rst_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_HOLD = 2'd0;
    localparam logic [STATE_W-1:0] S_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] S_RUN  = 2'd2;
    localparam logic [STATE_W-1:0] S_SOFT = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD = S_HOLD,
        ST_WAIT = S_WAIT,
        ST_RUN  = S_RUN,
        ST_SOFT = S_SOFT
    } seq_state_t;

    // Bits needed for a counter running 0..max_count-1, never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: assertion passes straight through, release appears after SYNC_STAGES clock edges.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_rst_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: holds reset, then releases stages one per acknowledged ready, serves sw re-resets.
// Optional stage-ready watchdog with automatic retry is built when RST_TIMEOUT_EN is defined.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_sw_rst_req,
    input  logic [NUM_STAGES-1:0] i_stage_ready,
    output logic [NUM_STAGES-1:0] o_stage_rst_n,
    output logic                  o_sys_ready,
    output logic                  o_sw_rst_ack,
    output logic [STATE_W-1:0]    o_seq_state,
    output logic                  o_timeout_err
);

    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 8 || HOLD_CYCLES < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("reset_sequencer: parameter out of range");
        end
    endgenerate

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int IDX_W  = cnt_width(NUM_STAGES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic                  w_rst_int_n;
    logic                  w_ready_cur;
    seq_state_t            r_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic                  r_sys_ready;
    logic                  r_sw_rst_ack;

`ifdef RST_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_timeout_err;
`endif

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_reset),
        .o_rst_n (w_rst_int_n)
    );

    // Only the stage currently being waited on matters; higher ready bits are don't-care.
    assign w_ready_cur = i_stage_ready[r_idx];

    always_ff @(posedge i_clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_state       <= ST_HOLD;
            r_hold_cnt    <= '0;
            r_idx         <= '0;
            r_stage_rst_n <= '0;
            r_sys_ready   <= 1'b0;
            r_sw_rst_ack  <= 1'b0;
`ifdef RST_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt       <= '0;
                        r_stage_rst_n[0] <= 1'b1;
                        r_idx            <= '0;
`ifdef RST_TIMEOUT_EN
                        r_wait_cnt       <= '0;
`endif
                        r_state          <= ST_WAIT;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (w_ready_cur) begin
`ifdef RST_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                        if (r_idx == IDX_LAST) begin
                            r_sys_ready <= 1'b1;
                            r_state     <= ST_RUN;
                        end else begin
                            r_stage_rst_n[r_idx + IDX_W'(1)] <= 1'b1;
                            r_idx                            <= r_idx + IDX_W'(1);
                        end
                    end
`ifdef RST_TIMEOUT_EN
                    // A stuck stage drops everything and retries the whole sequence from HOLD.
                    else if (r_wait_cnt == TO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_stage_rst_n <= '0;
                        r_state       <= ST_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                    end
`endif
                end
                ST_RUN: begin
                    if (i_sw_rst_req) begin
                        r_stage_rst_n <= '0;
                        r_sys_ready   <= 1'b0;
                        r_sw_rst_ack  <= 1'b1;
                        r_state       <= ST_SOFT;
                    end
                end
                ST_SOFT: begin
                    r_sw_rst_ack <= 1'b0;
                    r_hold_cnt   <= '0;
                    r_state      <= ST_HOLD;
                end
                default: r_state <= ST_HOLD;
            endcase
        end
    end

    assign o_stage_rst_n = r_stage_rst_n;
    assign o_sys_ready   = r_sys_ready;
    assign o_sw_rst_ack  = r_sw_rst_ack;
    assign o_seq_state   = r_state;
`ifdef RST_TIMEOUT_EN
    assign o_timeout_err = r_timeout_err;
`else
    assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: hand-derived vector table, corner sequences, then random traffic vs a stage-count model.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 16;
    localparam int SYNC = 2;
    localparam int TO   = 256;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req = 1'b0;
    logic [N-1:0] ready = '0;
    logic [N-1:0] stage_rst_n;
    logic         sys_ready;
    logic         sw_rst_ack;
    logic [1:0]   seq_state;
    logic         timeout_err;

    reset_sequencer #(
        .NUM_STAGES     (N),
        .HOLD_CYCLES    (HOLD),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_sw_rst_req  (req),
        .i_stage_ready (ready),
        .o_stage_rst_n (stage_rst_n),
        .o_sys_ready   (sys_ready),
        .o_sw_rst_ack  (sw_rst_ack),
        .o_seq_state   (seq_state),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: the sequence is described by how many stages are released plus a few phase flags.
    bit m_in_rst, m_run, m_soft, m_ack, m_sysr, m_terr;
    int m_sync_left, m_hold_done, m_released, m_wait_cnt;

    function automatic void model_reset();
        m_in_rst    = 1'b1;
        m_sync_left = SYNC;
        m_hold_done = 0;
        m_released  = 0;
        m_wait_cnt  = 0;
        m_run       = 1'b0;
        m_soft      = 1'b0;
        m_ack       = 1'b0;
        m_sysr      = 1'b0;
        m_terr      = 1'b0;
    endfunction

    function automatic void model_edge(input logic [N-1:0] rdy, input logic rq);
        if (m_in_rst) return;
        if (m_sync_left > 0) begin
            m_sync_left--;
            return;
        end
        if (m_soft) begin
            m_soft = 1'b0;
            m_ack = 1'b0;
            m_hold_done = 0;
        end else if (m_run) begin
            if (rq) begin
                m_released = 0;
                m_sysr = 1'b0;
                m_ack = 1'b1;
                m_run = 1'b0;
                m_soft = 1'b1;
            end
        end else if (m_released == 0) begin
            m_hold_done++;
            if (m_hold_done == HOLD) begin
                m_released = 1;
                m_hold_done = 0;
                m_wait_cnt = 0;
            end
        end else if (rdy[m_released-1]) begin
            m_wait_cnt = 0;
            if (m_released < N) m_released++;
            else begin
                m_sysr = 1'b1;
                m_run = 1'b1;
            end
        end else begin
`ifdef RST_TIMEOUT_EN
            if (m_wait_cnt == TO - 1) begin
                m_terr = 1'b1;
                m_released = 0;
                m_hold_done = 0;
            end else m_wait_cnt++;
`endif
        end
    endfunction

    task automatic check_model(input string tag);
        int exp_state;
        exp_state = m_soft ? 3 : m_run ? 2 : (m_released > 0) ? 1 : 0;
        chk({tag, ".stage_rst_n"}, 32'(stage_rst_n), 32'((1 << m_released) - 1));
        chk({tag, ".sys_ready"},   32'(sys_ready),   32'(m_sysr));
        chk({tag, ".sw_rst_ack"},  32'(sw_rst_ack),  32'(m_ack));
        chk({tag, ".seq_state"},   32'(seq_state),   32'(exp_state));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge(ready, req);
        #1;
        check_model(tag);
    endtask

    // Called 1ns after an edge: drops reset between edges, keeps it low for two edges, releases mid-cycle.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_model(tag);
        repeat (2) tick(tag);
        #2;
        reset = 1'b1;
        m_in_rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] rdy;
        logic         rq;
        int           cycles;
        logic [N-1:0] e_rst_n;
        logic         e_sr;
        logic         e_ack;
        logic [1:0]   e_st;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Expected values below are counted from reset release: 2 sync edges + 16 hold edges.
        tbl[0]  = '{3'b000, 1'b0, 17, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{3'b000, 1'b0,  1, 3'b001, 1'b0, 1'b0, 2'd1};
        tbl[2]  = '{3'b000, 1'b0,  5, 3'b001, 1'b0, 1'b0, 2'd1};
        tbl[3]  = '{3'b001, 1'b0,  1, 3'b011, 1'b0, 1'b0, 2'd1};
        tbl[4]  = '{3'b001, 1'b0,  3, 3'b011, 1'b0, 1'b0, 2'd1};
        tbl[5]  = '{3'b110, 1'b0,  1, 3'b111, 1'b0, 1'b0, 2'd1};
        tbl[6]  = '{3'b010, 1'b0,  1, 3'b111, 1'b0, 1'b0, 2'd1};
        tbl[7]  = '{3'b100, 1'b0,  1, 3'b111, 1'b1, 1'b0, 2'd2};
        tbl[8]  = '{3'b000, 1'b0,  4, 3'b111, 1'b1, 1'b0, 2'd2};
        tbl[9]  = '{3'b000, 1'b1,  1, 3'b000, 1'b0, 1'b1, 2'd3};
        tbl[10] = '{3'b000, 1'b0,  1, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[11] = '{3'b000, 1'b0, 15, 3'b000, 1'b0, 1'b0, 2'd0};
        tbl[12] = '{3'b000, 1'b0,  1, 3'b001, 1'b0, 1'b0, 2'd1};

        model_reset();
        #1;
        chk("rst.stage_rst_n", 32'(stage_rst_n), 32'h0);
        chk("rst.sys_ready",   32'(sys_ready),   32'h0);
        chk("rst.sw_rst_ack",  32'(sw_rst_ack),  32'h0);
        chk("rst.seq_state",   32'(seq_state),   32'h0);
        chk("rst.timeout_err", 32'(timeout_err), 32'h0);
        repeat (3) tick("inrst");
        #4;
        reset = 1'b1;
        m_in_rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            ready = tbl[i].rdy;
            req   = tbl[i].rq;
            repeat (tbl[i].cycles) tick("tbl_cyc");
            chk($sformatf("tbl%0d.stage_rst_n", i), 32'(stage_rst_n), 32'(tbl[i].e_rst_n));
            chk($sformatf("tbl%0d.sys_ready", i),   32'(sys_ready),   32'(tbl[i].e_sr));
            chk($sformatf("tbl%0d.sw_rst_ack", i),  32'(sw_rst_ack),  32'(tbl[i].e_ack));
            chk($sformatf("tbl%0d.seq_state", i),   32'(seq_state),   32'(tbl[i].e_st));
        end

        // sw request held through WAIT is ignored, then fires on the first RUN cycle.
        ready = 3'b000;
        req   = 1'b1;
        repeat (10) tick("swign");
        chk("swign.ack", 32'(sw_rst_ack), 32'h0);
        chk("swign.rst_n", 32'(stage_rst_n), 32'h1);
        ready = 3'b111;
        repeat (3) tick("swign");
        chk("swret.state_run", 32'(seq_state), 32'h2);
        chk("swret.ack_none", 32'(sw_rst_ack), 32'h0);
        tick("swret");
        chk("swret.ack", 32'(sw_rst_ack), 32'h1);
        chk("swret.rst_n", 32'(stage_rst_n), 32'h0);
        req = 1'b0;
        tick("swret");
        chk("swret.ack_once", 32'(sw_rst_ack), 32'h0);

        // Asynchronous reset mid-WAIT must clear outputs before the next edge.
        ready = 3'b001;
        repeat (17) tick("midwait");
        chk("midwait.rst_n", 32'(stage_rst_n), 32'h3);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("arst.stage_rst_n", 32'(stage_rst_n), 32'h0);
        chk("arst.sys_ready", 32'(sys_ready), 32'h0);
        chk("arst.seq_state", 32'(seq_state), 32'h0);
        repeat (2) tick("arst");
        #2;
        reset = 1'b1;
        m_in_rst = 1'b0;

        // Stage 1 never acknowledges: watchdog retry when built in, indefinite wait otherwise.
        repeat (19) tick("stuck");
        chk("stuck.rst_n", 32'(stage_rst_n), 32'h3);
        repeat (TO - 1) tick("stuck");
        chk("stuck.pre_err", 32'(timeout_err), 32'h0);
        tick("stuck");
`ifdef RST_TIMEOUT_EN
        chk("tmo.err", 32'(timeout_err), 32'h1);
        chk("tmo.rst_n", 32'(stage_rst_n), 32'h0);
        chk("tmo.state", 32'(seq_state), 32'h0);
`else
        chk("tmo.err_tied", 32'(timeout_err), 32'h0);
        chk("tmo.rst_n_held", 32'(stage_rst_n), 32'h3);
        chk("tmo.state_wait", 32'(seq_state), 32'h1);
`endif
        ready = 3'b111;
        repeat (19) tick("recover");
        chk("recover.sys_ready", 32'(sys_ready), 32'h1);
`ifdef RST_TIMEOUT_EN
        chk("recover.err_sticky", 32'(timeout_err), 32'h1);
`else
        chk("recover.err_tied", 32'(timeout_err), 32'h0);
`endif

        // Random traffic against the model, with occasional asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            ready = N'($urandom) & N'($urandom | $urandom);
            req   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 699) == 0) async_reset("rnd_arst");
            else tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
